// File: rtl/uart_rx_mmio.sv
// Receive-side UART buffer with a memory-mapped DATA/STATUS register pair.
// Bytes from the receiver queue in a circular FIFO that the CPU drains through DATA reads.
module uart_rx_mmio #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_ready,
  input  logic        sel,
  input  logic        we,
  input  logic        addr,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        irq
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  // Handshakes: rx_ready is a level, and a byte is taken once on its rising edge.
  // sel is a one-cycle strobe with no back-pressure; reads answer on rdata the next cycle.
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          overrun;
  logic          rx_q;

  logic          push_req, push_ok, pop, full, not_empty;
  logic          rd_data_acc, rd_stat_acc, ovr_clear, ovr_set;
  logic [4:0]    count5;
  logic [15:0]   status_word;

  always_comb begin
    not_empty   = (count != '0);
    full        = (count == CW'(DEPTH));
    push_req    = rx_ready & ~rx_q;
    rd_data_acc = sel & ~we & ~addr;
    rd_stat_acc = sel & ~we & addr;
    pop         = rd_data_acc & not_empty;
    // A full FIFO can still take a byte when a pop frees the head slot on the same edge.
    push_ok     = push_req & (~full | pop);
    ovr_set     = push_req & full & ~pop;
    ovr_clear   = sel & we & addr & wdata[2];
    count5      = 5'(count);
    status_word = {7'b0, count5, 1'b0, overrun, full, not_empty};
  end

  assign irq = not_empty;

  // Storage carries no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count   <= '0;
      overrun <= 1'b0;
      rx_q    <= 1'b0;
      rdata   <= 16'h0000;
    end else begin
      rx_q <= rx_ready;
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      if (push_ok && !pop)      count <= count + CW'(1);
      else if (pop && !push_ok) count <= count - CW'(1);
      // Setting beats clearing so an overrun in the clear cycle is not lost.
      if (ovr_set)        overrun <= 1'b1;
      else if (ovr_clear) overrun <= 1'b0;
      if (rd_data_acc)      rdata <= pop ? {8'h00, mem[rd_ptr]} : 16'h0000;
      else if (rd_stat_acc) rdata <= status_word;
    end
  end

endmodule

// File: tb/tb_uart_rx_mmio.sv
// Directed bench for uart_rx_mmio: a queue model of the FIFO supplies the expected bytes and STATUS words.
module tb_uart_rx_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        sel, we, addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        irq;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       model_ovr;

  uart_rx_mmio #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_ready(rx_ready),
    .sel(sel), .we(we), .addr(addr), .wdata(wdata), .rdata(rdata), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] model_status();
    logic [4:0] c;
    c = 5'(exp_q.size());
    return {7'b0, c, 1'b0, model_ovr, exp_q.size() == 8, exp_q.size() != 0};
  endfunction

  task automatic model_push(input logic [7:0] b, input bit same_pop);
    if (exp_q.size() < 8 || same_pop) exp_q.push_back(b);
    else model_ovr = 1'b1;
  endtask

  function automatic logic [15:0] model_pop();
    logic [7:0] b;
    if (exp_q.size() == 0) return 16'h0000;
    b = exp_q.pop_front();
    return {8'h00, b};
  endfunction

  task automatic push_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
    model_push(b, 1'b0);
  endtask

  task automatic read_reg(input logic a, output logic [15:0] d);
    @(negedge clk);
    sel  = 1'b1;
    we   = 1'b0;
    addr = a;
    @(negedge clk);
    sel  = 1'b0;
    d    = rdata;
  endtask

  task automatic write_reg(input logic a, input logic [15:0] d);
    @(negedge clk);
    sel   = 1'b1;
    we    = 1'b1;
    addr  = a;
    wdata = d;
    @(negedge clk);
    sel   = 1'b0;
    we    = 1'b0;
    wdata = 16'h0000;
  endtask

  task automatic check_status(input string tag);
    logic [15:0] d;
    read_reg(1'b1, d);
    check(tag, d, model_status());
  endtask

  task automatic check_data(input string tag);
    logic [15:0] d;
    logic [15:0] e;
    read_reg(1'b0, d);
    e = model_pop();
    check(tag, d, e);
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] e;
    logic [7:0]  b;
    rst = 1'b0; rx_data = 8'h00; rx_ready = 1'b0;
    sel = 1'b0; we = 1'b0; addr = 1'b0; wdata = 16'h0000;
    model_ovr = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rdata", rdata, 16'h0000);
    check("reset_irq", {15'b0, irq}, 16'h0000);
    rst = 1'b1;

    // Single byte round trip
    push_byte(8'h74);
    check("single_irq_set", {15'b0, irq}, 16'h0001);
    read_reg(1'b1, d);
    check("single_status", d, 16'h0011);
    read_reg(1'b0, d);
    e = model_pop();
    check("single_data_model", d, e);
    check("single_data", d, 16'h0074);
    check("single_irq_clear", {15'b0, irq}, 16'h0000);
    read_reg(1'b1, d);
    check("single_status_empty", d, 16'h0000);

    // Fill, overrun, writes that must not clear it, drain, clear
    for (int i = 1; i <= 8; i++) push_byte(8'(i));
    read_reg(1'b1, d);
    check("full_status", d, 16'h0083);
    push_byte(8'h09);
    read_reg(1'b1, d);
    check("overrun_status", d, 16'h0087);
    write_reg(1'b1, 16'hFFFB);
    write_reg(1'b0, 16'hFFFF);
    check_status("ignored_writes_status");
    for (int i = 1; i <= 8; i++) check_data("drain_order");
    write_reg(1'b1, 16'h0004);
    model_ovr = 1'b0;
    read_reg(1'b1, d);
    check("ovr_clear_status", d, 16'h0000);

    // Held level gives a single push
    @(negedge clk);
    rx_data  = 8'h55;
    rx_ready = 1'b1;
    repeat (10) @(negedge clk);
    rx_ready = 1'b0;
    model_push(8'h55, 1'b0);
    read_reg(1'b1, d);
    check("held_level_status", d, 16'h0011);
    check_data("held_level_data");
    check_status("held_level_empty");

    // Full FIFO with push and pop on the same edge
    for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
    @(negedge clk);
    rx_data  = 8'hAA;
    rx_ready = 1'b1;
    sel = 1'b1; we = 1'b0; addr = 1'b0;
    @(negedge clk);
    rx_ready = 1'b0;
    sel = 1'b0;
    e = model_pop();
    model_push(8'hAA, 1'b1);
    check("full_pushpop_data", rdata, e);
    read_reg(1'b1, d);
    check("full_pushpop_status", d, 16'h0083);
    for (int i = 0; i < 7; i++) check_data("full_pushpop_drain");
    read_reg(1'b0, d);
    e = model_pop();
    check("full_pushpop_last", d, 16'h00AA);
    check("full_pushpop_last_model", d, e);

    // Empty read and pointer wrap
    check_data("empty_read");
    check_status("empty_read_status");
    for (int i = 0; i < 20; i++) begin
      b = 8'($urandom_range(0, 255));
      push_byte(b);
      check_data("wrap_pair");
    end
    check_status("wrap_status");

    // Asynchronous reset in the middle of a cycle
    for (int i = 0; i < 3; i++) push_byte(8'($urandom_range(1, 255)));
    check_status("pre_reset_status");
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_rst_irq", {15'b0, irq}, 16'h0000);
    check("async_rst_rdata", rdata, 16'h0000);
    exp_q.delete();
    model_ovr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    read_reg(1'b1, d);
    check("post_reset_status", d, 16'h0000);
    check_data("post_reset_data");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
